// File: rtl/present_pkg.sv
// Shared PRESENT primitives: nibble S-box tables, the bit permutation and its inverse,
// and the state encoding used by the iterative core.
package present_pkg;

    localparam int BLOCK_WIDTH = 64;

    typedef enum logic [2:0] {
        IDLE,
        KEYGEN,
        ENC,
        DEC,
        DONE
    } state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    // Bit i moves to position 16*i mod 63; bit 63 stays where it is.
    function automatic logic [63:0] p_layer(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 63; i++) begin
            o[6'((16 * i) % 63)] = d[6'(i)];
        end
        o[63] = d[63];
        return o;
    endfunction

    function automatic logic [63:0] inv_p_layer(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 63; i++) begin
            o[6'(i)] = d[6'((16 * i) % 63)];
        end
        o[63] = d[63];
        return o;
    endfunction

    function automatic logic [63:0] sbox64(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[6'(4 * n) +: 4] = SBOX[d[6'(4 * n) +: 4]];
        end
        return o;
    endfunction

    function automatic logic [63:0] inv_sbox64(input logic [63:0] d);
        logic [63:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[6'(4 * n) +: 4] = INV_SBOX[d[6'(4 * n) +: 4]];
        end
        return o;
    endfunction

endpackage

// File: rtl/present_key_step.sv
// One step of the PRESENT key schedule: forward (K_r -> K_r+1) or inverse (K_r+1 -> K_r)
// for the round counter value on rnd.
module present_key_step
    import present_pkg::*;
#(
    parameter int KEY_SIZE = 80
) (
    input  logic [KEY_SIZE-1:0] key,
    input  logic [4:0]          rnd,
    input  logic                dir,
    output logic [KEY_SIZE-1:0] key_next
);

    localparam int CNT_LSB = (KEY_SIZE == 128) ? 62 : 15;

    logic [KEY_SIZE-1:0] fwd_rot;
    logic [KEY_SIZE-1:0] fwd_key;
    logic [KEY_SIZE-1:0] inv_sub;
    logic [KEY_SIZE-1:0] inv_key;

    // NOTE: every variable of a combinational block gets a full value before any
    // conditional update, so no path can leave it holding state (no latch).
    always_comb begin
        fwd_rot = {key[KEY_SIZE-62:0], key[KEY_SIZE-1:KEY_SIZE-61]};
        fwd_key = fwd_rot;
        fwd_key[KEY_SIZE-1 -: 4] = SBOX[fwd_rot[KEY_SIZE-1 -: 4]];
        if (KEY_SIZE == 128) begin
            fwd_key[KEY_SIZE-5 -: 4] = SBOX[fwd_rot[KEY_SIZE-5 -: 4]];
        end
        fwd_key[CNT_LSB +: 5] = fwd_rot[CNT_LSB +: 5] ^ rnd;

        // Inverse undoes the forward operations in reverse order.
        inv_sub = key;
        inv_sub[CNT_LSB +: 5] = key[CNT_LSB +: 5] ^ rnd;
        inv_sub[KEY_SIZE-1 -: 4] = INV_SBOX[key[KEY_SIZE-1 -: 4]];
        if (KEY_SIZE == 128) begin
            inv_sub[KEY_SIZE-5 -: 4] = INV_SBOX[key[KEY_SIZE-5 -: 4]];
        end
        inv_key = {inv_sub[60:0], inv_sub[KEY_SIZE-1:61]};

        key_next = dir ? inv_key : fwd_key;
    end

endmodule

// File: rtl/present_iter_core.sv
// Iterative PRESENT encrypt/decrypt engine, one round per clock, with on-the-fly key
// schedule and a one-entry cache of the last round key to shortcut repeated decrypts.
module present_iter_core
    import present_pkg::*;
#(
    parameter int KEY_SIZE   = 80,
    parameter int BLOCK_SIZE = 64,
    parameter int NUM_ROUNDS = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_decrypt,
    input  logic [KEY_SIZE-1:0]   in_key,
    input  logic [BLOCK_SIZE-1:0] in_block,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BLOCK_SIZE-1:0] out_block,
    output logic                  out_cache_hit
);

    if (KEY_SIZE != 80 && KEY_SIZE != 128) begin : g_bad_key_size
        $error("present_iter_core: KEY_SIZE must be 80 or 128");
    end
    if (BLOCK_SIZE != BLOCK_WIDTH) begin : g_bad_block_size
        $error("present_iter_core: BLOCK_SIZE must be 64");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_num_rounds
        $error("present_iter_core: NUM_ROUNDS must be in 1..31");
    end

    localparam logic [4:0] LAST_RND = 5'(NUM_ROUNDS);

    state_t                state;
    state_t                state_next;
    logic [4:0]            rnd;
    logic [KEY_SIZE-1:0]   key_q;
    logic [63:0]           data_q;
    logic [KEY_SIZE-1:0]   orig_key;
    logic [KEY_SIZE-1:0]   cache_key;
    logic [KEY_SIZE-1:0]   cache_last;
    logic                  cache_valid;
    logic [KEY_SIZE-1:0]   key_step_out;
    logic                  key_dir;
    logic                  hit;
    logic                  rnd_last;
    logic                  rnd_first;
    logic [63:0]           round_out;
    logic [63:0]           inv_round_out;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign key_dir   = (state == DEC);
    assign hit       = cache_valid && (in_key == cache_key);
    assign rnd_last  = (rnd == LAST_RND);
    assign rnd_first = (rnd == 5'd1);

    present_key_step #(
        .KEY_SIZE(KEY_SIZE)
    ) u_key_step (
        .key      (key_q),
        .rnd      (rnd),
        .dir      (key_dir),
        .key_next (key_step_out)
    );

    assign round_out     = p_layer(sbox64(data_q ^ key_q[KEY_SIZE-1 -: 64]));
    assign inv_round_out = inv_sbox64(inv_p_layer(data_q)) ^ key_step_out[KEY_SIZE-1 -: 64];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid) state_next = !in_decrypt ? ENC : (hit ? DEC : KEYGEN);
            KEYGEN:  if (rnd_last) state_next = DEC;
            ENC:     if (rnd_last) state_next = DONE;
            DEC:     if (rnd_first) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the cache registers are reset along with the datapath; a stale cache_valid
    // after reset would let a decrypt use a round key from before the reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd           <= '0;
            key_q         <= '0;
            data_q        <= '0;
            orig_key      <= '0;
            cache_key     <= '0;
            cache_last    <= '0;
            cache_valid   <= 1'b0;
            out_block     <= '0;
            out_cache_hit <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        orig_key      <= in_key;
                        out_cache_hit <= in_decrypt && hit;
                        if (in_decrypt && hit) begin
                            rnd    <= LAST_RND;
                            key_q  <= cache_last;
                            data_q <= in_block ^ cache_last[KEY_SIZE-1 -: 64];
                        end else begin
                            rnd    <= 5'd1;
                            key_q  <= in_key;
                            data_q <= in_block;
                        end
                    end
                end
                ENC: begin
                    key_q  <= key_step_out;
                    data_q <= round_out;
                    if (rnd_last) begin
                        out_block   <= round_out ^ key_step_out[KEY_SIZE-1 -: 64];
                        cache_key   <= orig_key;
                        cache_last  <= key_step_out;
                        cache_valid <= 1'b1;
                    end else begin
                        rnd <= rnd + 5'd1;
                    end
                end
                KEYGEN: begin
                    key_q <= key_step_out;
                    if (rnd_last) begin
                        // Counter stays at the last round: DEC walks it back down.
                        data_q      <= data_q ^ key_step_out[KEY_SIZE-1 -: 64];
                        cache_key   <= orig_key;
                        cache_last  <= key_step_out;
                        cache_valid <= 1'b1;
                    end else begin
                        rnd <= rnd + 5'd1;
                    end
                end
                DEC: begin
                    key_q  <= key_step_out;
                    data_q <= inv_round_out;
                    if (rnd_first) begin
                        out_block <= inv_round_out;
                    end else begin
                        rnd <= rnd - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_present_iter_core.sv
// Bench for present_iter_core: 80- and 128-bit instances checked against known answers
// and a round-key-array reference model of PRESENT.
module tb_present_iter_core;

    localparam int NR = 31;
    localparam logic [63:0] SB_TABLE = 64'hC56B90AD3EF84712;

    logic clk;
    logic rst_n;

    logic         v80, ir80, d80, ov80, rdy80, hit80;
    logic [79:0]  k80;
    logic [63:0]  b80, ob80;
    logic         v128, ir128, d128, ov128, rdy128, hit128;
    logic [127:0] k128;
    logic [63:0]  b128, ob128;

    int checks   = 0;
    int failures = 0;

    present_iter_core #(.KEY_SIZE(80), .BLOCK_SIZE(64), .NUM_ROUNDS(NR)) u_dut80 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v80), .in_ready(ir80), .in_decrypt(d80), .in_key(k80), .in_block(b80),
        .out_valid(ov80), .out_ready(rdy80), .out_block(ob80), .out_cache_hit(hit80)
    );

    present_iter_core #(.KEY_SIZE(128), .BLOCK_SIZE(64), .NUM_ROUNDS(NR)) u_dut128 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v128), .in_ready(ir128), .in_decrypt(d128), .in_key(k128), .in_block(b128),
        .out_valid(ov128), .out_ready(rdy128), .out_block(ob128), .out_cache_hit(hit128)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] sb(input logic [3:0] x);
        logic [63:0] t;
        t = SB_TABLE >> (4 * (15 - int'(x)));
        return t[3:0];
    endfunction

    function automatic logic [3:0] isb(input logic [3:0] y);
        for (int v = 0; v < 16; v++) begin
            if (sb(4'(v)) == y) return 4'(v);
        end
        return 4'h0;
    endfunction

    function automatic logic [63:0] sub_layer(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        logic [3:0]  x;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            x = 4'(s >> (4 * n));
            o = o | (64'(inv ? isb(x) : sb(x)) << (4 * n));
        end
        return o;
    endfunction

    function automatic logic [63:0] perm(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        int          j;
        o = '0;
        for (int i = 0; i < 64; i++) begin
            j = (i == 63) ? 63 : (16 * i) % 63;
            if (!inv) o[j] = s[i];
            else      o[i] = s[j];
        end
        return o;
    endfunction

    task automatic model(input bit wide, input bit dec, input logic [127:0] key,
                         input logic [63:0] blk, output logic [63:0] res);
        logic [63:0]  rk [1:NR+1];
        logic [127:0] k, mask;
        logic [3:0]   nib;
        logic [63:0]  s;
        int           ks;
        ks   = wide ? 128 : 80;
        mask = wide ? '1 : ((128'(1) << 80) - 128'(1));
        k    = key & mask;
        for (int r = 1; r <= NR + 1; r++) begin
            rk[r] = 64'(k >> (ks - 64));
            k = ((k << 61) | (k >> (ks - 61))) & mask;
            nib = 4'(k >> (ks - 4));
            k = (k & ~(128'hF << (ks - 4))) | (128'(sb(nib)) << (ks - 4));
            if (wide) begin
                nib = 4'(k >> (ks - 8));
                k = (k & ~(128'hF << (ks - 8))) | (128'(sb(nib)) << (ks - 8));
            end
            k = k ^ (128'(r) << (wide ? 62 : 15));
        end
        if (!dec) begin
            s = blk;
            for (int r = 1; r <= NR; r++) s = perm(sub_layer(s ^ rk[r], 1'b0), 1'b0);
            res = s ^ rk[NR+1];
        end else begin
            s = blk ^ rk[NR+1];
            for (int r = NR; r >= 1; r--) s = sub_layer(perm(s, 1'b1), 1'b1) ^ rk[r];
            res = s;
        end
    endtask

    // One request/response on either instance with out_ready held high. The inputs are
    // scrambled right after the accept edge to show they were captured there.
    task automatic run_op(input bit wide, input bit dec, input logic [127:0] key,
                          input logic [63:0] blk, output logic [63:0] res,
                          output logic hit, output int lat);
        lat = -1;
        res = '0;
        hit = 1'b0;
        if (wide) begin v128 = 1'b1; d128 = dec; k128 = key; b128 = blk; end
        else begin v80 = 1'b1; d80 = dec; k80 = key[79:0]; b80 = blk; end
        @(posedge clk); #1;
        v80 = 1'b0; v128 = 1'b0;
        d80 = ~d80; d128 = ~d128; k80 = ~k80; k128 = ~k128; b80 = ~b80; b128 = ~b128;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if ((wide ? ov128 : ov80) === 1'b1) begin
                lat = i;
                res = wide ? ob128 : ob80;
                hit = wide ? hit128 : hit80;
                break;
            end
        end
        if (lat != -1) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [63:0]  res, exp, held, pt, ct;
        logic [127:0] key, kc, kx;
        logic         hit;
        int           lat, seen;

        rst_n = 1'b0;
        v80 = 1'b0; d80 = 1'b0; k80 = '0; b80 = '0; rdy80 = 1'b1;
        v128 = 1'b0; d128 = 1'b0; k128 = '0; b128 = '0; rdy128 = 1'b1;
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready80", 128'(ir80), 128'(1));
        check("rst_out_valid80", 128'(ov80), 128'(0));
        check("rst_out_block80", 128'(ob80), 128'(0));
        check("rst_cache_hit80", 128'(hit80), 128'(0));
        check("rst_in_ready128", 128'(ir128), 128'(1));
        check("rst_out_valid128", 128'(ov128), 128'(0));

        // Cold-cache decrypt, then the same decrypt again from the cache.
        key = 128'({80{1'b1}});
        run_op(1'b0, 1'b1, key, 64'hE72C46C0F5945049, res, hit, lat);
        check("kat_dec_miss_pt", 128'(res), 128'(0));
        check("kat_dec_miss_hit", 128'(hit), 128'(0));
        check("kat_dec_miss_lat", 128'(lat), 128'(62));
        run_op(1'b0, 1'b1, key, 64'hE72C46C0F5945049, res, hit, lat);
        check("kat_dec_rep_pt", 128'(res), 128'(0));
        check("kat_dec_rep_hit", 128'(hit), 128'(1));
        check("kat_dec_rep_lat", 128'(lat), 128'(31));

        run_op(1'b0, 1'b0, 128'(0), 64'h0, res, hit, lat);
        check("kat_enc80_zero", 128'(res), 128'(64'h5579C1387B228445));
        check("kat_enc80_zero_lat", 128'(lat), 128'(31));

        run_op(1'b0, 1'b0, key, 64'hFFFFFFFFFFFFFFFF, res, hit, lat);
        check("kat_enc80_ones", 128'(res), 128'(64'h3333DCD3213210D2));
        run_op(1'b0, 1'b1, key, 64'h3333DCD3213210D2, res, hit, lat);
        check("kat_dec80_ones", 128'(res), 128'(64'hFFFFFFFFFFFFFFFF));
        check("kat_dec80_ones_hit", 128'(hit), 128'(1));
        check("kat_dec80_ones_lat", 128'(lat), 128'(31));

        run_op(1'b1, 1'b0, 128'(0), 64'h0, res, hit, lat);
        check("kat_enc128_zero", 128'(res), 128'(64'h96DB702A2E6900AF));
        check("kat_enc128_lat", 128'(lat), 128'(31));
        run_op(1'b1, 1'b1, 128'(0), 64'h96DB702A2E6900AF, res, hit, lat);
        check("kat_dec128_zero", 128'(res), 128'(0));
        check("kat_dec128_hit", 128'(hit), 128'(1));

        // Random round trips and cold decrypts on both key sizes.
        for (int t = 0; t < 6; t++) begin
            bit wide;
            wide = (t >= 4);
            key = wide ? {$urandom(), $urandom(), $urandom(), $urandom()}
                       : 128'({$urandom(), $urandom(), 16'($urandom())});
            pt = {$urandom(), $urandom()};
            model(wide, 1'b0, key, pt, exp);
            run_op(wide, 1'b0, key, pt, res, hit, lat);
            check("rnd_enc", 128'(res), 128'(exp));
            check("rnd_enc_lat", 128'(lat), 128'(31));
            ct = res;
            run_op(wide, 1'b1, key, ct, res, hit, lat);
            check("rnd_dec_hit_pt", 128'(res), 128'(pt));
            check("rnd_dec_hit", 128'(hit), 128'(1));
            check("rnd_dec_hit_lat", 128'(lat), 128'(31));
            kx = wide ? {$urandom(), $urandom(), $urandom(), $urandom()}
                      : 128'({$urandom(), $urandom(), 16'($urandom())});
            ct = {$urandom(), $urandom()};
            model(wide, 1'b1, kx, ct, exp);
            run_op(wide, 1'b1, kx, ct, res, hit, lat);
            check("rnd_dec_miss_pt", 128'(res), 128'(exp));
            check("rnd_dec_miss_hit", 128'(hit), 128'(0));
            check("rnd_dec_miss_lat", 128'(lat), 128'(62));
        end

        // Output back-pressure: result held, no new request accepted.
        kc = 128'({$urandom(), $urandom(), 16'($urandom())});
        pt = {$urandom(), $urandom()};
        model(1'b0, 1'b0, kc, pt, exp);
        rdy80 = 1'b0;
        v80 = 1'b1; d80 = 1'b0; k80 = kc[79:0]; b80 = pt;
        @(posedge clk); #1;
        v80 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (ov80 === 1'b1) begin lat = i; break; end
        end
        check("bp_lat", 128'(lat), 128'(31));
        check("bp_result", 128'(ob80), 128'(exp));
        held = ob80;
        for (int i = 0; i < 10; i++) begin
            v80 = 1'(i % 2); d80 = 1'b1;
            k80 = 80'({$urandom(), $urandom(), 16'($urandom())});
            b80 = {$urandom(), $urandom()};
            @(posedge clk); #1;
            check("bp_block_stable", 128'(ob80), 128'(held));
            check("bp_valid_held", 128'(ov80), 128'(1));
            check("bp_in_ready_low", 128'(ir80), 128'(0));
        end
        v80 = 1'b0;
        rdy80 = 1'b1;
        check("bp_no_turnaround", 128'(ir80), 128'(0));
        @(posedge clk); #1;
        check("bp_valid_dropped", 128'(ov80), 128'(0));
        check("bp_in_ready_back", 128'(ir80), 128'(1));
        check("bp_block_kept", 128'(ob80), 128'(held));

        // Reset in the middle of a cold decrypt wipes the cache entry for kc.
        kx = kc ^ 128'(80'h1);
        v80 = 1'b1; d80 = 1'b1; k80 = kx[79:0]; b80 = {$urandom(), $urandom()};
        @(posedge clk); #1;
        v80 = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 128'(ov80), 128'(0));
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 128'(ir80), 128'(1));
        check("post_rst_block", 128'(ob80), 128'(0));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ov80 !== 1'b0) seen++;
        end
        check("post_rst_no_result", 128'(seen), 128'(0));
        model(1'b0, 1'b0, kc, pt, ct);
        run_op(1'b0, 1'b1, kc, ct, res, hit, lat);
        check("post_rst_dec_pt", 128'(res), 128'(pt));
        check("post_rst_dec_hit", 128'(hit), 128'(0));
        check("post_rst_dec_lat", 128'(lat), 128'(62));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
